uart_rx_core: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 8N1 RX FSM. Adds configurable data width,

---
 rtl/uart_rx_core.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Parametrised UART receiver. The asynchronous rx line goes through a two-flop
// synchroniser. A falling edge starts a frame, and the start bit is confirmed at
// mid-bit. Data bits are then sampled LSB first at bit centres, followed by the
// optional parity bit and STOP_BITS stop bits. A good word is offered on a
// valid/ready interface. A good word that arrives while the previous one is
// still pending is dropped, and an overrun pulse is raised.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the data.
// The expected parity bit is ^data ^ parity_odd. Without the macro there is no
// parity bit, parity_odd is ignored and parity_err stays 0.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  baud_tick pulses per bit period (even, 8..32)
//   STOP_BITS   stop bits checked (1 or 2)
// Ports
//   clk, areset_n   clock, asynchronous active-low reset
//   sync_clr        synchronous clear, same effect as reset
//   rx_en           start enable, looked at only while idle
//   baud_tick       1-cycle strobe at OVERSAMPLE x baud
//   rx              raw serial input, idle high
//   parity_odd      1 = odd parity, 0 = even
//   m_data/m_valid  received word and its valid flag; m_ready accepts it
//   busy            frame in progress
//   frame_err       1-cycle pulse: a stop bit was sampled low
//   parity_err      1-cycle pulse: parity mismatch
//   overrun         1-cycle pulse: good word dropped, previous one not taken
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 sync_clr,
  input  logic                 rx_en,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int N_W = $clog2(DATA_BITS);
  localparam logic [S_W-1:0] S_HALF      = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST      = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_DATA_LAST = N_W'(DATA_BITS - 1);
  localparam logic [N_W-1:0] N_STOP_LAST = N_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nxt;
  logic [S_W-1:0]       s, s_nxt;
  logic [N_W-1:0]       n, n_nxt;
  logic                 rx_meta, rx_s, rx_prev;
  logic [DATA_BITS-1:0] data_sr;
  logic                 bad;
  logic                 sample_data, sample_stop, frame_end;
  logic                 start_edge, stop_bad, par_bad, word_ok, word_load;
`ifdef UART_RX_PARITY_EN
  logic                 sample_par, par_bit;
`endif

  assign start_edge = rx_prev & ~rx_s;
  assign busy       = (state != IDLE);

  // State and counters.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
    end else if (sync_clr) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      n     <= n_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    s_nxt       = s;
    n_nxt       = n;
    sample_data = 1'b0;
    sample_stop = 1'b0;
    frame_end   = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        s_nxt = '0;
        n_nxt = '0;
        if (start_edge && rx_en) state_nxt = START;
      end
      START: if (baud_tick) begin
        if (s == S_HALF) begin
          // A line that is high again at mid-start is a glitch: drop it silently.
          s_nxt     = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          s_nxt = s + 1'b1;
        end
      end
      DATA: if (baud_tick) begin
        if (s == S_LAST) begin
          s_nxt       = '0;
          sample_data = 1'b1;
          if (n == N_DATA_LAST) begin
            n_nxt = '0;
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            n_nxt = n + 1'b1;
          end
        end else begin
          s_nxt = s + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (baud_tick) begin
        if (s == S_LAST) begin
          s_nxt      = '0;
          sample_par = 1'b1;
          state_nxt  = STOP;
        end else begin
          s_nxt = s + 1'b1;
        end
      end
`endif
      STOP: if (baud_tick) begin
        if (s == S_LAST) begin
          s_nxt       = '0;
          sample_stop = 1'b1;
          if (n == N_STOP_LAST) begin
            n_nxt     = '0;
            frame_end = 1'b1;
            state_nxt = IDLE;
          end else begin
            n_nxt = n + 1'b1;
          end
        end else begin
          s_nxt = s + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)       par_bit <= 1'b0;
    else if (sync_clr)   par_bit <= 1'b0;
    else if (sample_par) par_bit <= rx_s;
  end
  assign par_bad = par_bit ^ (^data_sr) ^ parity_odd;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign par_bad           = 1'b0;
`endif

  // The last stop sample is folded in directly, because it lands in the same
  // cycle as frame_end.
  assign stop_bad  = bad | ~rx_s;
  assign word_ok   = frame_end & ~stop_bad & ~par_bad;
  assign word_load = word_ok & (~m_valid | m_ready);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      data_sr    <= '0;
      bad        <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (sync_clr) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      data_sr    <= '0;
      bad        <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      frame_err  <= frame_end & stop_bad;
      parity_err <= frame_end & ~stop_bad & par_bad;
      overrun    <= word_ok & m_valid & ~m_ready;
      if (sample_data) data_sr[n] <= rx_s;
      if (state == IDLE)                 bad <= 1'b0;
      else if (sample_stop && !rx_s)     bad <= 1'b1;
      if (word_load) begin
        m_data  <= data_sr;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core. DUT a uses the default parameters (8 data
// bits, 16x oversampling, 1 stop bit). DUT b has STOP_BITS=2 and shares all
// inputs with DUT a. Frames are driven one baud_tick every two clocks.
// Outputs are sampled on the falling clock edge.
// The parity step is built only when UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       sync_clr = 1'b0;
  logic       rx_en = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       parity_odd = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] m_data_a, m_data_b;
  logic       m_valid_a, m_valid_b, busy_a, busy_b;
  logic       frame_err_a, frame_err_b, parity_err_a, parity_err_b;
  logic       overrun_a, overrun_b;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Pulse and m_valid-rise counters, sampled away from the active edge.
  int   fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, mv_rise = 0;
  logic mv_q = 1'b0;
  int   fe0, pe0, ov0, mv0;

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
    .clk(clk), .areset_n(areset_n), .sync_clr(sync_clr), .rx_en(rx_en),
    .baud_tick(baud_tick), .rx(rx), .parity_odd(parity_odd),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .busy(busy_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a)
  );

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2)) dut_b (
    .clk(clk), .areset_n(areset_n), .sync_clr(sync_clr), .rx_en(rx_en),
    .baud_tick(baud_tick), .rx(rx), .parity_odd(parity_odd),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .busy(busy_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b)
  );

  always @(negedge clk) begin
    mv_q <= m_valid_a;
    if (frame_err_a)           fe_cnt  <= fe_cnt + 1;
    if (parity_err_a)          pe_cnt  <= pe_cnt + 1;
    if (overrun_a)             ov_cnt  <= ov_cnt + 1;
    if (m_valid_a && !mv_q)    mv_rise <= mv_rise + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int k);
    repeat (k) begin
      @(negedge clk); baud_tick = 1'b1;
      @(negedge clk); baud_tick = 1'b0;
    end
  endtask

  // Drives a whole frame, but stops 8 ticks into the last stop bit, one tick
  // before the receiver samples it. The first start tick is absorbed by the
  // synchroniser, so every bit is sampled on its 9th tick.
  task automatic send_head(input logic [7:0] data, input int nstop,
                           input logic stop0, input logic stop_last);
    rx = 1'b0; tick_n(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i]; tick_n(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ parity_odd ^ par_flip; tick_n(16);
`endif
    if (nstop == 2) begin
      rx = stop0; tick_n(16);
    end
    rx = stop_last; tick_n(8);
  endtask

  task automatic snap();
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; mv0 = mv_rise;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst m_valid", 32'(m_valid_a), 32'd0);
    check("rst m_data", 32'(m_data_a), 32'h00);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst flags", 32'({frame_err_a, parity_err_a, overrun_a}), 32'd0);
    areset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: good frame 0xA5, latency of exactly one clock after the stop sample
    snap();
    send_head(8'hA5, 1, 1'b1, 1'b1);
    check("t1 valid before stop sample", 32'(m_valid_a), 32'd0);
    check("t1 busy", 32'(busy_a), 32'd1);
    tick_n(1);
    check("t1 valid", 32'(m_valid_a), 32'd1);
    check("t1 data", 32'(m_data_a), 32'hA5);
    @(negedge clk);
    check("t1 valid clears on ready", 32'(m_valid_a), 32'd0);
    rx = 1'b1; tick_n(8);
    check("t1 no flags", 32'(fe_cnt - fe0 + pe_cnt - pe0 + ov_cnt - ov0), 32'd0);

    // 2: false start, line low for 4 ticks only
    snap();
    rx = 1'b0; tick_n(4);
    check("t2 busy in start", 32'(busy_a), 32'd1);
    rx = 1'b1; tick_n(12);
    check("t2 busy dropped", 32'(busy_a), 32'd0);
    check("t2 no valid", 32'(mv_rise - mv0), 32'd0);
    check("t2 no flags", 32'(fe_cnt - fe0 + pe_cnt - pe0 + ov_cnt - ov0), 32'd0);

    // 3: 0x3C with a low stop bit, then the line stays low
    snap();
    send_head(8'h3C, 1, 1'b1, 1'b0);
    tick_n(1);
    check("t3 frame_err", 32'(frame_err_a), 32'd1);
    check("t3 other pulses", 32'({parity_err_a, overrun_a}), 32'd0);
    @(negedge clk);
    check("t3 frame_err width", 32'(frame_err_a), 32'd0);
    tick_n(20);
    check("t3 held low no start", 32'(busy_a), 32'd0);
    rx = 1'b1; tick_n(4);
    check("t3 no valid", 32'(mv_rise - mv0), 32'd0);

    // rx_en low in idle: no frame starts
    rx_en = 1'b0;
    rx = 1'b0; tick_n(4);
    check("rx_en off no start", 32'(busy_a), 32'd0);
    rx = 1'b1; tick_n(4);
    rx_en = 1'b1;

    // 4: consumer stalled, second word overruns
    m_ready = 1'b0;
    send_head(8'h11, 1, 1'b1, 1'b1);
    tick_n(1);
    check("t4 first valid", 32'(m_valid_a), 32'd1);
    check("t4 first data", 32'(m_data_a), 32'h11);
    rx = 1'b1; tick_n(8);
    send_head(8'h22, 1, 1'b1, 1'b1);
    tick_n(1);
    check("t4 overrun", 32'(overrun_a), 32'd1);
    check("t4 data kept", 32'(m_data_a), 32'h11);
    check("t4 valid kept", 32'(m_valid_a), 32'd1);
    @(negedge clk);
    check("t4 overrun width", 32'(overrun_a), 32'd0);
    rx = 1'b1; tick_n(8);
    m_ready = 1'b1;
    @(negedge clk);
    check("t4 valid clears", 32'(m_valid_a), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 5: odd parity. 0x37 has five ones, so the expected parity bit is
    // ^data ^ 1 = 0; sending 1 is a mismatch.
    parity_odd = 1'b1;
    par_flip   = 1'b1;
    send_head(8'h37, 1, 1'b1, 1'b1);
    tick_n(1);
    check("t5 parity_err", 32'(parity_err_a), 32'd1);
    check("t5 no valid", 32'(m_valid_a), 32'd0);
    rx = 1'b1; tick_n(8);
    par_flip = 1'b0;
    send_head(8'h37, 1, 1'b1, 1'b1);
    tick_n(1);
    check("t5 good parity valid", 32'(m_valid_a), 32'd1);
    check("t5 good parity data", 32'(m_data_a), 32'h37);
    check("t5 no parity_err", 32'(parity_err_a), 32'd0);
    rx = 1'b1; tick_n(8);
    parity_odd = 1'b0;
`endif

    // 6: asynchronous reset in the middle of data bit 4
    rx = 1'b0; tick_n(16);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h5A >> i); tick_n(16);
    end
    rx = 1'(8'h5A >> 4); tick_n(8);
    check("t6 busy mid data", 32'(busy_a), 32'd1);
    @(negedge clk);
    areset_n = 1'b0;
    #1;
    check("t6 reset busy", 32'(busy_a), 32'd0);
    check("t6 reset data", 32'(m_data_a), 32'h00);
    check("t6 reset outputs", 32'({m_valid_a, frame_err_a, parity_err_a, overrun_a}), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    areset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_head(8'h5A, 1, 1'b1, 1'b1);
    tick_n(1);
    check("t6 after reset valid", 32'(m_valid_a), 32'd1);
    check("t6 after reset data", 32'(m_data_a), 32'h5A);
    rx = 1'b1; tick_n(8);

    // sync_clr mid-frame behaves like reset
    rx = 1'b0; tick_n(20);
    check("clr busy before", 32'(busy_a), 32'd1);
    sync_clr = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    check("clr busy", 32'(busy_a), 32'd0);
    check("clr data", 32'(m_data_a), 32'h00);
    tick_n(4);

    // 6b: two stop bits, good frame, then a low second stop bit
    @(negedge clk);
    areset_n = 1'b0;
    @(negedge clk);
    areset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_head(8'hC3, 2, 1'b1, 1'b1);
    check("t6b valid before 2nd stop", 32'(m_valid_b), 32'd0);
    tick_n(1);
    check("t6b valid", 32'(m_valid_b), 32'd1);
    check("t6b data", 32'(m_data_b), 32'hC3);
    rx = 1'b1; tick_n(8);
    send_head(8'h5A, 2, 1'b1, 1'b0);
    tick_n(1);
    check("t6b frame_err", 32'(frame_err_b), 32'd1);
    check("t6b no valid", 32'(m_valid_b), 32'd0);
    check("t6b data kept", 32'(m_data_b), 32'hC3);
    rx = 1'b1; tick_n(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
